// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with row debouncing and an eight-digit entry shift register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module hex_keypad_scanner #(
  parameter int SCAN_DIV         = 25000,
  parameter int DEBOUNCE_SAMPLES = 20,
  parameter int REPEAT_SAMPLES   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] entry,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2, RELEASE = 2'd3} state_t;

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]      DB_TGT   = 8'(DEBOUNCE_SAMPLES);

  if (SCAN_DIV < 4 || DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 255 || REPEAT_SAMPLES < 1)
  begin : g_bad_params
    $error("hex_keypad_scanner: illegal parameter value");
  end

  state_t           r_state, w_state_nx;
  logic [3:0]       r_row_meta, r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx, w_col_idx_nx;
  logic [1:0]       r_row_idx, w_row_idx_nx;
  logic [7:0]       r_cnt, w_cnt_nx;
  logic             r_key_valid, w_valid_nx;
  logic [3:0]       r_key_code, w_code_nx;
  logic             r_key_down, w_down_nx;
  logic [31:0]      r_entry, w_entry_nx;
  logic             w_sample, w_any_low, w_latched_low, w_accept;
  logic [1:0]       w_low_idx;
  logic [3:0]       w_new_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int              REP_W    = (REPEAT_SAMPLES > 1) ? $clog2(REPEAT_SAMPLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SAMPLES - 1);
  logic [REP_W-1:0] r_rep, w_rep_nx;
`endif

  // Row lines are asynchronous to clk: two-flop synchronizer, idle level all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_sample = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div <= '0;
    else      r_div <= w_sample ? '0 : r_div + DIV_W'(1);
  end

  assign w_any_low     = ~&r_row_sync;
  assign w_latched_low = ~r_row_sync[r_row_idx];
  assign w_new_code    = {r_row_idx, r_col_idx};

  always_comb begin
    w_low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_sync[i]) w_low_idx = 2'(i);
    end
  end

  // key_valid is a one-cycle strobe with no back-pressure; key_code and entry
  // already carry the new keystroke in the same cycle the strobe is high.
  always_comb begin
    w_state_nx   = r_state;
    w_col_idx_nx = r_col_idx;
    w_row_idx_nx = r_row_idx;
    w_cnt_nx     = r_cnt;
    w_valid_nx   = 1'b0;
    w_code_nx    = r_key_code;
    w_down_nx    = r_key_down;
    w_entry_nx   = clr ? 32'h0 : r_entry;
    w_accept     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_nx     = r_rep;
`endif
    case (r_state)
      SCAN: begin
        if (w_sample) begin
          if (w_any_low) begin
            w_row_idx_nx = w_low_idx;
            w_cnt_nx     = 8'd1;
            w_state_nx   = DEBOUNCE;
          end else begin
            w_col_idx_nx = r_col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        // Acceptance lands the cycle after the final sample, never on a sample point.
        if (r_cnt == DB_TGT) begin
          w_accept   = 1'b1;
          w_down_nx  = 1'b1;
          w_state_nx = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
          w_rep_nx   = '0;
`endif
        end else if (w_sample) begin
          if (w_latched_low) begin
            w_cnt_nx = r_cnt + 8'd1;
          end else begin
            w_state_nx   = SCAN;
            w_col_idx_nx = r_col_idx + 2'd1;
          end
        end
      end
      HOLD: begin
        if (w_sample) begin
          if (!w_latched_low) begin
            if (DB_TGT == 8'd1) begin
              w_down_nx    = 1'b0;
              w_col_idx_nx = r_col_idx + 2'd1;
              w_state_nx   = SCAN;
            end else begin
              w_cnt_nx   = 8'd1;
              w_state_nx = RELEASE;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (r_rep == REP_LAST) begin
            w_accept = 1'b1;
            w_rep_nx = '0;
          end else begin
            w_rep_nx = r_rep + REP_W'(1);
          end
`endif
        end
      end
      RELEASE: begin
        if (w_sample) begin
          if (w_latched_low) begin
            w_state_nx = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_nx   = '0;
`endif
          end else if (r_cnt + 8'd1 == DB_TGT) begin
            w_down_nx    = 1'b0;
            w_col_idx_nx = r_col_idx + 2'd1;
            w_state_nx   = SCAN;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_nx = SCAN;
    endcase
    if (w_accept) begin
      w_valid_nx = 1'b1;
      w_code_nx  = w_new_code;
      w_entry_nx = clr ? {28'h0, w_new_code} : {r_entry[27:0], w_new_code};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SCAN;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_cnt       <= 8'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_key_down  <= 1'b0;
      r_entry     <= 32'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_col_idx   <= w_col_idx_nx;
      r_row_idx   <= w_row_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_key_valid <= w_valid_nx;
      r_key_code  <= w_code_nx;
      r_key_down  <= w_down_nx;
      r_entry     <= w_entry_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= w_rep_nx;
`endif
    end
  end

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_down  = r_key_down;
  assign entry     = r_entry;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner with a small keypad model and keystroke scoreboard.
module tb_hex_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;

  localparam logic [1:0] ST_SCAN = 2'd0, ST_DEBOUNCE = 2'd1, ST_HOLD = 2'd2;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] exp_entry;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic        clr = 1'b0;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] entry;
  logic [1:0]  dbg_state;

  // keypad model
  logic       kp_down = 1'b0, kp_raw = 1'b0, kp_force_high = 1'b0;
  logic [1:0] kp_r = 2'd0, kp_c = 2'd0;

  int n_checks = 0, n_errors = 0, n_valid = 0, n_samples = 0, cyc = 0;
  logic [35:0] exp_q[$];
  vec_t        vecs[9];
  logic [3:0]  col_tab[5];

  hex_keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SAMPLES(DEB), .REPEAT_SAMPLES(REP)) dut (
    .clk(clk), .rst(rst), .row(row), .clr(clr), .col(col), .key_valid(key_valid),
    .key_code(key_code), .key_down(key_down), .entry(entry), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    if ((kp_down && !kp_force_high && !col[kp_c]) || kp_raw) row[kp_r] = 1'b0;
  end

  // Sample points fall every SCAN_DIV cycles counted from reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else begin
      cyc <= cyc + 1;
      if ((cyc + 1) % SCAN_DIV == 0) n_samples <= n_samples + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    if (rst && key_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_key_valid: got key_code %h entry %h, expected no pulse", key_code, entry);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {28'h0, key_code}, {28'h0, e[35:32]});
        check("entry", entry, e[31:0]);
        check("key_down_at_valid", {31'h0, key_down}, 32'h1);
      end
    end
  end

  task automatic wait_samples(input int n);
    int target;
    target = n_samples + n;
    while (n_samples < target) @(negedge clk);
  endtask

  task automatic wait_valid(input int prev);
    int t = 0;
    while (n_valid == prev && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("key_valid_timeout", {31'h0, n_valid != prev}, 32'h1);
  endtask

  task automatic wait_release();
    int t = 0;
    while (key_down && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("key_down_release", {31'h0, key_down}, 32'h0);
  endtask

  task automatic press_key(input logic [3:0] k, input logic [31:0] exp_entry, input int hold);
    int prev;
    kp_r = k[3:2];
    kp_c = k[1:0];
    exp_q.push_back({k, exp_entry});
    prev = n_valid;
    kp_down = 1'b1;
    wait_valid(prev);
    if (hold > 0) wait_samples(hold);
    kp_down = 1'b0;
    wait_release();
  endtask

  initial begin
    int prev;
    col_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    vecs = '{'{4'h1, 32'h00000001}, '{4'h2, 32'h00000012}, '{4'h3, 32'h00000123},
             '{4'h4, 32'h00001234}, '{4'h5, 32'h00012345}, '{4'h6, 32'h00123456},
             '{4'h7, 32'h01234567}, '{4'h8, 32'h12345678}, '{4'h9, 32'h23456789}};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_col", {28'h0, col}, 32'h0000000E);
    check("rst_key_valid", {31'h0, key_valid}, 32'h0);
    check("rst_key_code", {28'h0, key_code}, 32'h0);
    check("rst_key_down", {31'h0, key_down}, 32'h0);
    check("rst_entry", entry, 32'h0);
    rst = 1'b1;

    // idle scan: each column value held SCAN_DIV cycles
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle_col_%0d", i), {28'h0, col}, {28'h0, col_tab[i / SCAN_DIV]});
      @(negedge clk);
    end

    // key A: row 2, column 2
    press_key(4'hA, 32'h0000000A, 0);
    check("release_col_idx3", {28'h0, col}, 32'h00000007);
    check("key_code_held", {28'h0, key_code}, 32'h0000000A);

    // bounce: two low samples then high
    wait_samples(1);
    kp_r = 2'd1;
    kp_raw = 1'b1;
    wait_samples(1);
    check("bounce_in_debounce", {30'h0, dbg_state}, {30'h0, ST_DEBOUNCE});
    wait_samples(1);
    kp_raw = 1'b0;
    wait_samples(1);
    check("bounce_back_scan", {30'h0, dbg_state}, {30'h0, ST_SCAN});
    check("bounce_key_down", {31'h0, key_down}, 32'h0);

    // glitch while held: two high samples then low again
    kp_r = 2'd1;
    kp_c = 2'd3;
    exp_q.push_back({4'h7, 32'h000000A7});
    prev = n_valid;
    kp_down = 1'b1;
    wait_valid(prev);
    wait_samples(1);
    kp_force_high = 1'b1;
    wait_samples(2);
    kp_force_high = 1'b0;
    wait_samples(3);
    check("glitch_hold_state", {30'h0, dbg_state}, {30'h0, ST_HOLD});
    check("glitch_key_down", {31'h0, key_down}, 32'h1);
    check("glitch_single_valid", n_valid - prev, 32'h1);
    kp_down = 1'b0;
    wait_release();

    // clr alone
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_entry", entry, 32'h0);

    // nine keystrokes, top digit wraps off
    for (int i = 0; i < 9; i++) press_key(vecs[i].key, vecs[i].exp_entry, 0);
    check("nine_keys_entry", entry, 32'h23456789);

    // tenth key 0 accepted while clr is high
    clr = 1'b1;
    press_key(4'h0, 32'h00000000, 0);
    clr = 1'b0;
    check("clr_key0_entry", entry, 32'h0);
    check("clr_key0_code", {28'h0, key_code}, 32'h0);

    // reset during DEBOUNCE
    wait_samples(1);
    kp_r = 2'd3;
    kp_raw = 1'b1;
    wait_samples(1);
    check("pre_rst_debounce", {30'h0, dbg_state}, {30'h0, ST_DEBOUNCE});
    rst = 1'b0;
    @(negedge clk);
    kp_raw = 1'b0;
    @(negedge clk);
    check("mid_rst_col", {28'h0, col}, 32'h0000000E);
    check("mid_rst_key_down", {31'h0, key_down}, 32'h0);
    check("mid_rst_state", {30'h0, dbg_state}, {30'h0, ST_SCAN});
    prev = n_valid;
    rst = 1'b1;
    check("post_rst_col", {28'h0, col}, 32'h0000000E);
    check("post_rst_key_code", {28'h0, key_code}, 32'h0);
    check("post_rst_entry", entry, 32'h0);
    wait_samples(6);
    check("post_rst_no_valid", n_valid - prev, 32'h0);

    // key 5 held 3 debounce + 11 hold samples
    prev = n_valid;
    exp_q.push_back({4'h5, 32'h00000005});
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q.push_back({4'h5, 32'h00000055});
    exp_q.push_back({4'h5, 32'h00000555});
`endif
    kp_r = 2'd1;
    kp_c = 2'd1;
    kp_down = 1'b1;
    wait_valid(prev);
    wait_samples(11);
    kp_down = 1'b0;
    wait_release();
`ifdef KEYPAD_AUTOREPEAT_EN
    check("repeat_pulses", n_valid - prev, 32'h3);
    check("repeat_entry", entry, 32'h00000555);
`else
    check("repeat_pulses", n_valid - prev, 32'h1);
    check("repeat_entry", entry, 32'h00000005);
`endif

    wait_samples(2);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
